switch_conditioner: RTL and testbench

Conditions the four raw board switches into clean, glitch-free control events for the game core. Each raw input is synchronized, debounced and edge-detected, then turned into one-cycle move pulses with hold-to-repeat. A four-switch chord is detected separately and used for game start. The block sits between the physical switch pins and the character-control and game-state logic, and replaces their direct use of raw switch levels.

---
 rtl/switch_conditioner_pkg.sv | 37 +++
 rtl/switch_conditioner_debounce.sv | 65 ++++++
 rtl/switch_conditioner.sv | 125 ++++++++++++
 tb/tb_switch_conditioner.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/switch_conditioner_pkg.sv
// Shared constants for switch conditioning: timing defaults, direction indices,
// move-FSM state encodings and the priority-select helper.
package switch_conditioner_pkg;

   localparam int DEBOUNCE_LIMIT_DEF = 250000;
   localparam int REPEAT_DELAY_DEF   = 12500000;
   localparam int REPEAT_PERIOD_DEF  = 5000000;

   localparam int NUM_SW = 4;

   localparam logic [1:0] DIR_UP = 2'd0;
   localparam logic [1:0] DIR_LT = 2'd1;
   localparam logic [1:0] DIR_RT = 2'd2;
   localparam logic [1:0] DIR_DN = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2,
      ST_CHORD  = 2'd3
   } move_state_t;

   // Lowest index wins: Up > Left > Right > Down. Caller guarantees lvl != 0.
   function automatic logic [1:0] prio_sel(input logic [3:0] lvl);
      logic [1:0] sel;
      sel = DIR_DN;
      if (lvl[DIR_RT]) sel = DIR_RT;
      if (lvl[DIR_LT]) sel = DIR_LT;
      if (lvl[DIR_UP]) sel = DIR_UP;
      return sel;
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/switch_conditioner_debounce.sv
// One switch channel: 2-flop synchronizer, debounce counter, stable level and
// registered press/release edge pulses.
module switch_debounce
   import switch_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF
) (
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_Raw,
   output logic o_Level,
   output logic o_Press,
   output logic o_Release
);

   localparam int              CW       = cnt_width(DEBOUNCE_LIMIT);
   localparam logic [CW-1:0]   CNT_TERM = CW'(DEBOUNCE_LIMIT - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          prev_q;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Counter only advances while the synchronized input disagrees with the level.
   always_comb begin
      level_d   = level_q;
      cnt_d     = '0;
      press_d   = level_q & ~prev_q;
      release_d = ~level_q & prev_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_TERM) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         prev_q    <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= i_Raw;
         sync2_q   <= sync1_q;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         prev_q    <= level_q;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign o_Level   = level_q;
   assign o_Press   = press_q;
   assign o_Release = release_q;

endmodule

// File: rtl/switch_conditioner.sv
// Turns the four raw board switches into debounced levels, edge pulses,
// prioritized move pulses with hold-to-repeat, and a four-switch chord pulse.
//
// state     | meaning
// ST_IDLE   | no selection; picks highest-priority held switch and pulses it
// ST_HOLD   | selection held, waiting REPEAT_DELAY for the first repeat
// ST_REPEAT | selection held, pulsing every REPEAT_PERIOD
// ST_CHORD  | all four were pressed; moves suppressed until all released
module switch_conditioner
   import switch_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF,
   parameter int REPEAT_DELAY   = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD  = REPEAT_PERIOD_DEF
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic [3:0] i_Switch,
   output logic [3:0] o_Switch_Level,
   output logic [3:0] o_Press_Pulse,
   output logic [3:0] o_Release_Pulse,
   output logic [3:0] o_Move_Pulse,
   output logic       o_All_Pressed
);

   localparam int            RPT_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int            RW         = cnt_width(RPT_MAX);
   localparam logic [RW-1:0] DELAY_TERM = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_TERM = RW'(REPEAT_PERIOD - 1);

   logic [3:0]    lvl;
   logic [3:0]    lvl_prev_q;
   move_state_t   state_q, state_d;
   logic [1:0]    sel_q, sel_d;
   logic [RW-1:0] cnt_q, cnt_d;
   logic [3:0]    move_q, move_d;
   logic          all_q, all_d;
   logic          chord_entry;
   logic [1:0]    hi_sel;

   for (genvar g = 0; g < NUM_SW; g++) begin : g_deb
      switch_debounce #(
         .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
      ) u_deb (
         .i_Clk     (i_Clk),
         .i_Rst_L   (i_Rst_L),
         .i_Raw     (i_Switch[g]),
         .o_Level   (lvl[g]),
         .o_Press   (o_Press_Pulse[g]),
         .o_Release (o_Release_Pulse[g])
      );
   end

   assign chord_entry = (lvl == 4'hF) && (lvl_prev_q != 4'hF);
   assign hi_sel      = prio_sel(lvl);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      move_d  = 4'h0;
      all_d   = 1'b0;
      if (chord_entry) begin
         state_d = ST_CHORD;
         all_d   = 1'b1;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (lvl != 4'h0 && lvl != 4'hF) begin
                  sel_d   = hi_sel;
                  move_d  = 4'b0001 << hi_sel;
                  cnt_d   = '0;
                  state_d = ST_HOLD;
               end
            end
            ST_HOLD, ST_REPEAT: begin
               if (!lvl[sel_q]) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (hi_sel < sel_q) begin
                  // A higher-priority switch preempts and restarts the delay.
                  sel_d   = hi_sel;
                  move_d  = 4'b0001 << hi_sel;
                  cnt_d   = '0;
                  state_d = ST_HOLD;
               end else if (cnt_q == ((state_q == ST_HOLD) ? DELAY_TERM : PERIOD_TERM)) begin
                  move_d  = 4'b0001 << sel_q;
                  cnt_d   = '0;
                  state_d = ST_REPEAT;
               end else begin
                  cnt_d = cnt_q + RW'(1);
               end
            end
            ST_CHORD: begin
               if (lvl == 4'h0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         state_q    <= ST_IDLE;
         sel_q      <= DIR_UP;
         cnt_q      <= '0;
         move_q     <= 4'h0;
         all_q      <= 1'b0;
         lvl_prev_q <= 4'h0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         cnt_q      <= cnt_d;
         move_q     <= move_d;
         all_q      <= all_d;
         lvl_prev_q <= lvl;
      end
   end

   assign o_Switch_Level = lvl;
   assign o_Move_Pulse   = move_q;
   assign o_All_Pressed  = all_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench: stimulus pushes expected pulse events (cycle + all outputs),
// a negedge monitor pops and compares whenever any pulse output is active.
module tb_switch_conditioner;

   localparam int DL = 4;
   localparam int RD = 10;
   localparam int RP = 5;

   logic       clk   = 1'b0;
   logic       rst_l = 1'b0;
   logic [3:0] sw    = 4'h0;
   logic [3:0] o_Switch_Level, o_Press_Pulse, o_Release_Pulse, o_Move_Pulse;
   logic       o_All_Pressed;

   int cyc   = 0;
   int n_vec = 0;
   int n_bad = 0;
   int t;

   typedef struct {
      int         c;
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] rel;
      logic [3:0] mov;
      logic       all;
   } ev_t;

   ev_t exp_q[$];
   ev_t got_e;

   switch_conditioner #(
      .DEBOUNCE_LIMIT(DL),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
   ) dut (
      .i_Clk          (clk),
      .i_Rst_L        (rst_l),
      .i_Switch       (sw),
      .o_Switch_Level (o_Switch_Level),
      .o_Press_Pulse  (o_Press_Pulse),
      .o_Release_Pulse(o_Release_Pulse),
      .o_Move_Pulse   (o_Move_Pulse),
      .o_All_Pressed  (o_All_Pressed)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void push(input int c, input logic [3:0] lvl, input logic [3:0] prs,
                                input logic [3:0] rel, input logic [3:0] mov, input logic all);
      ev_t e;
      e.c = c; e.lvl = lvl; e.prs = prs; e.rel = rel; e.mov = mov; e.all = all;
      exp_q.push_back(e);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_eq(input string nm, input logic [3:0] act, input logic [3:0] want);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s got=%b want=%b", nm, act, want);
      end
   endtask

   always @(negedge clk) begin
      if (rst_l === 1'b1 &&
          (((o_Press_Pulse | o_Release_Pulse | o_Move_Pulse) != 4'h0) || o_All_Pressed === 1'b1)) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event cyc=%0d lvl=%b prs=%b rel=%b mov=%b all=%b",
                     cyc, o_Switch_Level, o_Press_Pulse, o_Release_Pulse, o_Move_Pulse, o_All_Pressed);
         end else begin
            got_e = exp_q.pop_front();
            if (got_e.c != cyc || got_e.lvl !== o_Switch_Level || got_e.prs !== o_Press_Pulse ||
                got_e.rel !== o_Release_Pulse || got_e.mov !== o_Move_Pulse || got_e.all !== o_All_Pressed) begin
               n_bad++;
               $display("FAIL event got cyc=%0d lvl=%b prs=%b rel=%b mov=%b all=%b want cyc=%0d lvl=%b prs=%b rel=%b mov=%b all=%b",
                        cyc, o_Switch_Level, o_Press_Pulse, o_Release_Pulse, o_Move_Pulse, o_All_Pressed,
                        got_e.c, got_e.lvl, got_e.prs, got_e.rel, got_e.mov, got_e.all);
            end
         end
      end
   end

   initial begin
      // Reset with all switches held
      rst_l = 1'b0;
      sw    = 4'hF;
      tick(3);
      check_eq("rst_level",   o_Switch_Level,        4'h0);
      check_eq("rst_press",   o_Press_Pulse,         4'h0);
      check_eq("rst_release", o_Release_Pulse,       4'h0);
      check_eq("rst_move",    o_Move_Pulse,          4'h0);
      check_eq("rst_all",     {3'b0, o_All_Pressed}, 4'h0);
      rst_l = 1'b1;
      t = cyc;
      push(t + 7, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1);
      tick(10);
      sw = 4'h0; t = cyc;
      push(t + 7, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0);
      tick(12);

      // Bounce on Up, then steady hold with repeats, then release
      for (int k = 0; k < 5; k++) begin
         sw = 4'h1; tick(3);
         sw = 4'h0; tick(1);
      end
      sw = 4'h1; t = cyc;
      push(t + 7, 4'h1, 4'h1, 4'h0, 4'h1, 1'b0);
      push(t + 17, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0);
      push(t + 22, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0);
      push(t + 27, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0);
      push(t + 32, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0);
      push(t + 37, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0);
      push(t + 42, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0);
      tick(40);
      sw = 4'h0;
      push(t + 47, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0);
      tick(12);

      // Left and Down together, then drop Left so Down gets reselected
      sw = 4'b1010; t = cyc;
      push(t + 7, 4'b1010, 4'b1010, 4'h0, 4'b0010, 1'b0);
      tick(8);
      sw = 4'b1000;
      push(t + 15, 4'b1000, 4'h0, 4'b0010, 4'h0, 1'b0);
      push(t + 16, 4'b1000, 4'h0, 4'h0, 4'b1000, 1'b0);
      tick(9);
      sw = 4'h0;
      push(t + 24, 4'h0, 4'h0, 4'b1000, 4'h0, 1'b0);
      tick(12);

      // Right repeating, Up preempts and restarts the delay
      sw = 4'b0100; t = cyc;
      push(t + 7, 4'b0100, 4'b0100, 4'h0, 4'b0100, 1'b0);
      push(t + 17, 4'b0100, 4'h0, 4'h0, 4'b0100, 1'b0);
      push(t + 22, 4'b0100, 4'h0, 4'h0, 4'b0100, 1'b0);
      tick(18);
      sw = 4'b0101;
      push(t + 25, 4'b0101, 4'b0001, 4'h0, 4'b0001, 1'b0);
      push(t + 35, 4'b0101, 4'h0, 4'h0, 4'b0001, 1'b0);
      tick(15);
      sw = 4'h0;
      push(t + 40, 4'h0, 4'h0, 4'b0101, 4'h0, 1'b0);
      tick(12);

      // Chord, partial release, full release, fresh Right
      sw = 4'hF; t = cyc;
      push(t + 7, 4'hF, 4'hF, 4'h0, 4'h0, 1'b1);
      tick(10);
      sw = 4'b0100;
      push(t + 17, 4'b0100, 4'h0, 4'b1011, 4'h0, 1'b0);
      tick(20);
      sw = 4'h0;
      push(t + 37, 4'h0, 4'h0, 4'b0100, 4'h0, 1'b0);
      tick(15);
      sw = 4'b0100;
      push(t + 52, 4'b0100, 4'b0100, 4'h0, 4'b0100, 1'b0);
      tick(9);
      sw = 4'h0;
      push(t + 61, 4'h0, 4'h0, 4'b0100, 4'h0, 1'b0);
      tick(12);

      // Reset mid-hold: Down held through reset is re-debounced from scratch
      sw = 4'b1000; t = cyc;
      push(t + 7, 4'b1000, 4'b1000, 4'h0, 4'b1000, 1'b0);
      tick(9);
      rst_l = 1'b0;
      tick(1);
      check_eq("midrst_level", o_Switch_Level, 4'h0);
      check_eq("midrst_move",  o_Move_Pulse,   4'h0);
      rst_l = 1'b1; t = cyc;
      push(t + 7, 4'b1000, 4'b1000, 4'h0, 4'b1000, 1'b0);
      tick(9);
      sw = 4'h0;
      push(t + 16, 4'h0, 4'h0, 4'b1000, 4'h0, 1'b0);
      tick(20);

      while (exp_q.size() > 0) begin
         got_e = exp_q.pop_front();
         n_vec++;
         n_bad++;
         $display("FAIL missing_event want cyc=%0d lvl=%b prs=%b rel=%b mov=%b all=%b got none",
                  got_e.c, got_e.lvl, got_e.prs, got_e.rel, got_e.mov, got_e.all);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
